// File: rtl/jtag_tap_sequencer.sv
// jtag_tap_sequencer: accepts one scan command at a time, walks the TAP from
// Run-Test/Idle through Capture/Shift/Exit1/Update, and returns the captured
// TDO bits as a right-aligned response word.
//
// Command handshake: a command transfers on a rising CLK edge where
// cmd_valid=1 and cmd_ready=1; cmd_op/cmd_len/cmd_data must be stable while
// cmd_valid is high, and cmd_valid is ignored whenever cmd_ready=0.
module jtag_tap_sequencer #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck_en,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output logic [2:0]         o_dbg_state
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_IDLE = 2'b11;

  typedef enum logic [2:0] {
    S_RST_SEQ = 3'd0,
    S_IDLE    = 3'd1,
    S_PRE     = 3'd2,
    S_SHIFT   = 3'd3,
    S_POST    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  state_t             w_dispatch;
  logic [LEN_W-1:0]   r_cnt;      // step index within the current phase
  logic               r_run;      // low for the first edge after reset so no step overlaps reset
  logic               r_cmd_rst;  // RST_SEQ was commanded (ends in DONE, not IDLE)
  logic [1:0]         r_op;
  logic [LEN_W-1:0]   r_last;     // normalised length minus one
  logic [MAX_LEN-1:0] r_data;     // TDI bits still to shift, LSB next
  logic [MAX_LEN-1:0] r_cap;      // TDO bits collected so far
  logic [MAX_LEN-1:0] r_rsp;
  logic [LEN_W-1:0]   w_len_norm;
  logic               w_accept;
  logic               w_is_scan;

  assign w_accept    = cmd_valid & cmd_ready;
  assign w_is_scan   = (r_op != OP_IDLE);
  assign rsp_data    = r_rsp;
  assign o_dbg_state = r_state;

  // Decode an incoming command: clamp its length and pick its first phase.
  always_comb begin
    w_len_norm = cmd_len;
    if (cmd_len == '0)
      w_len_norm = LEN_W'(1);
    else if (cmd_len > LEN_W'(MAX_LEN))
      w_len_norm = LEN_W'(MAX_LEN);
    case (cmd_op)
      OP_RST:  w_dispatch = S_RST_SEQ;
      OP_IDLE: w_dispatch = S_SHIFT;
      default: w_dispatch = S_PRE;
    endcase
  end

  // State register and per-phase step counter; the counter restarts on every phase change.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_RST_SEQ;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state)
        r_cnt <= '0;
      else if (tck_en)
        r_cnt <= r_cnt + LEN_W'(1);
    end
  end

  // Next state and the TAP/handshake outputs for the current step.
  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    tck_en       = 1'b0;
    TMS          = 1'b0;
    TDI          = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      S_RST_SEQ: begin
        tck_en = r_run;
        TMS    = (r_cnt < LEN_W'(5));
        if (r_run && r_cnt == LEN_W'(5))
          w_next_state = r_cmd_rst ? S_DONE : S_IDLE;
      end
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid)
          w_next_state = w_dispatch;
      end
      S_PRE: begin
        tck_en = 1'b1;
        if (r_op == OP_IR) begin
          TMS = (r_cnt < LEN_W'(2));
          if (r_cnt == LEN_W'(3))
            w_next_state = S_SHIFT;
        end else begin
          TMS = (r_cnt == '0);
          if (r_cnt == LEN_W'(2))
            w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        tck_en = 1'b1;
        if (w_is_scan) begin
          TDI = r_data[0];
          TMS = (r_cnt == r_last);
        end
        if (r_cnt == r_last)
          w_next_state = w_is_scan ? S_POST : S_DONE;
      end
      S_POST: begin
        tck_en = 1'b1;
        TMS    = (r_cnt == '0);
        if (r_cnt == LEN_W'(1))
          w_next_state = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        cmd_ready = 1'b1;
        busy      = 1'b0;
        w_next_state = cmd_valid ? w_dispatch : S_IDLE;
      end
      default: w_next_state = S_RST_SEQ;
    endcase
  end

  // Command latch, TDI shifter, TDO capture and response register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_run     <= 1'b0;
      r_cmd_rst <= 1'b0;
      r_op      <= OP_RST;
      r_last    <= '0;
      r_data    <= '0;
      r_cap     <= '0;
      r_rsp     <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_op      <= cmd_op;
        r_last    <= w_len_norm - LEN_W'(1);
        r_data    <= cmd_data;
        r_cap     <= '0;
        r_cmd_rst <= (cmd_op == OP_RST);
      end else begin
        if (r_state == S_SHIFT && w_is_scan) begin
          r_data                    <= r_data >> 1;
          r_cap[r_cnt[IDX_W-1:0]]   <= TDO;
        end
        if (w_next_state == S_DONE && r_state != S_DONE)
          r_rsp <= r_cap;
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb_jtag_tap_sequencer: directed and randomized scan commands checked
// against a step-list reference model built from the TAP walking rules.
module tb_jtag_tap_sequencer;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  // Clock / reset
  logic               CLK = 1'b0;
  logic               nRST = 1'b0;
  logic               cmd_valid = 1'b0;
  logic [1:0]         cmd_op = 2'b00;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               TDO = 1'b0;
  logic               cmd_ready, rsp_valid, busy, tck_en, TMS, TDI;
  logic [MAX_LEN-1:0] rsp_data;
  logic [2:0]         dbg_state;

  always #5 CLK = ~CLK;

  jtag_tap_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck_en(tck_en), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .o_dbg_state(dbg_state)
  );

  // Scoreboard
  int                 checks = 0;
  int                 failures = 0;
  logic [MAX_LEN-1:0] exp_q[$];
  logic [MAX_LEN-1:0] last_rsp = '0;

  // Reference model: expected per-step TMS/TDI and the shift window
  bit m_tms[$];
  bit m_tdi[$];
  int m_lo;
  int m_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int norm_len(input int len);
    if (len == 0) return 1;
    if (len > MAX_LEN) return MAX_LEN;
    return len;
  endfunction

  function automatic logic [31:0] len_mask(input int l);
    if (l >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << l) - 32'd1;
  endfunction

  function automatic void model_cmd(input logic [1:0] op, input int len, input logic [31:0] data);
    int l;
    l = norm_len(len);
    m_tms.delete();
    m_tdi.delete();
    m_lo = 0;
    m_n  = 0;
    case (op)
      2'b00: for (int i = 0; i < 6; i++) begin m_tms.push_back(i < 5); m_tdi.push_back(1'b0); end
      2'b11: for (int i = 0; i < l; i++) begin m_tms.push_back(1'b0); m_tdi.push_back(1'b0); end
      default: begin
        m_tms.push_back(1'b1); m_tdi.push_back(1'b0);
        if (op == 2'b01) begin m_tms.push_back(1'b1); m_tdi.push_back(1'b0); end
        m_tms.push_back(1'b0); m_tdi.push_back(1'b0);
        m_tms.push_back(1'b0); m_tdi.push_back(1'b0);
        m_lo = m_tms.size();
        m_n  = l;
        for (int i = 0; i < l; i++) begin
          m_tms.push_back(i == l - 1);
          m_tdi.push_back(data[i]);
        end
        m_tms.push_back(1'b1); m_tdi.push_back(1'b0);
        m_tms.push_back(1'b0); m_tdi.push_back(1'b0);
      end
    endcase
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_outs"}, {26'd0, TMS, TDI, tck_en, cmd_ready, busy, rsp_valid}, 32'b100010);
    chk({tag, "_rsp"}, rsp_data, 32'd0);
  endtask

  // Called at a negedge with nRST low; releases reset and checks the power-on walk.
  task automatic power_on();
    chk_reset_vals("in_reset");
    nRST = 1'b1;
    last_rsp = '0;
    @(posedge CLK);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk($sformatf("por_step%0d", k), {26'd0, tck_en, TMS, TDI, busy, cmd_ready, rsp_valid},
          {26'd0, 1'b1, (k < 5) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      chk($sformatf("por_rsp%0d", k), rsp_data, 32'd0);
    end
    @(negedge CLK);
    chk("por_ready", {28'd0, tck_en, busy, cmd_ready, rsp_valid}, 32'b0010);
  endtask

  // Driver: issue one command at a negedge where the DUT should be ready,
  // then check every step and the completion cycle.
  task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                         input logic [31:0] pat, input int abort_step, input bit hold);
    logic [31:0] exp_rsp;
    int          l;
    model_cmd(op, len, data);
    l = norm_len(len);
    exp_rsp = (op == 2'b01 || op == 2'b10) ? (pat & len_mask(l)) : 32'd0;
    chk("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len[LEN_W-1:0];
    cmd_data  = data;
    exp_q.push_back(exp_rsp);
    @(posedge CLK);
    for (int k = 0; k < m_tms.size(); k++) begin
      @(negedge CLK);
      if (k == abort_step) begin
        nRST = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk_reset_vals("abort");
        void'(exp_q.pop_back());
        return;
      end
      chk($sformatf("op%0d_len%0d_step%0d", op, len, k),
          {26'd0, tck_en, TMS, TDI, busy, cmd_ready, rsp_valid},
          {26'd0, 1'b1, m_tms[k], m_tdi[k], 1'b1, 1'b0, 1'b0});
      chk($sformatf("rsp_stable_step%0d", k), rsp_data, last_rsp);
      if (k == 0 && !hold) cmd_valid = 1'b0;
      if (k >= m_lo && k < m_lo + m_n) TDO = pat[k - m_lo];
      else TDO = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    chk($sformatf("op%0d_len%0d_done", op, len), {28'd0, tck_en, busy, cmd_ready, rsp_valid}, 32'b0011);
    last_rsp = exp_q.pop_front();
    chk($sformatf("op%0d_len%0d_rsp", op, len), rsp_data, last_rsp);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    chk("idle_outs", {28'd0, tck_en, busy, cmd_ready, rsp_valid}, 32'b0010);
    chk("idle_rsp", rsp_data, last_rsp);
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    repeat (3) @(negedge CLK);
    power_on();

    run_cmd(2'b10, 8, 32'h0000_00A5, 32'h0000_003C, -1, 1'b0);
    idle_cycle();
    run_cmd(2'b01, 5, 32'h0000_001F, 32'hFFFF_FFFF, -1, 1'b0);
    idle_cycle();
    run_cmd(2'b10, 0, $urandom, $urandom, -1, 1'b0);
    idle_cycle();
    run_cmd(2'b10, 40, $urandom, $urandom, -1, 1'b0);
    idle_cycle();
    run_cmd(2'b00, 4, $urandom, $urandom, -1, 1'b0);
    idle_cycle();
    run_cmd(2'b01, 32, $urandom, $urandom, -1, 1'b0);

    // Back-to-back: idle op held straight into a DR scan
    run_cmd(2'b11, 3, $urandom, $urandom, -1, 1'b1);
    run_cmd(2'b10, 8, $urandom, $urandom, -1, 1'b0);
    idle_cycle();

    // Randomized commands, some issued back-to-back
    for (int n = 0; n < 24; n++) begin
      bit b2b;
      b2b = 1'($urandom_range(0, 1));
      run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 40), $urandom, $urandom, -1, b2b);
      if (!b2b) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) idle_cycle();
      end
    end
    cmd_valid = 1'b0;
    idle_cycle();

    // Reset during the shift phase of a 16-bit DR scan
    run_cmd(2'b10, 16, $urandom, $urandom, 8, 1'b0);
    repeat (2) begin
      @(negedge CLK);
      chk_reset_vals("held_reset");
    end
    power_on();
    run_cmd(2'b10, 12, $urandom, $urandom, -1, 1'b0);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_tap_sequencer.md
# jtag_tap_sequencer

Host-side command sequencer that drives a JTAG TAP controller through complete IR and DR scans. It accepts one scan command at a time, generates the TMS/TDI bit stream that walks the TAP from Run-Test/Idle through Capture, Shift, Exit1 and Update, and collects TDO into a response word. It sits between the debug/test command source and the TAP-side logic: it owns TMS, TDI and the TCK step enable, and consumes TDO.

## Interface
- MAX_LEN, 32, maximum scan length in bits; also the width of the data and response words.
- LEN_W, $clog2(MAX_LEN)+1, width of cmd_len; must be able to hold MAX_LEN.

Ports:
- CLK  in  1  system clock; one TAP step per CLK cycle in which tck_en=1.
- nRST  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00=TAP reset, 01=IR scan, 10=DR scan, 11=idle cycles.
- cmd_len  in  LEN_W  scan length in bits, or idle cycle count.
- cmd_data  in  MAX_LEN  TDI data, shifted LSB first.
- rsp_valid  out  1  one-cycle pulse when the command completes.
- rsp_data  out  MAX_LEN  captured TDO bits, right-aligned; held until the next rsp_valid.
- busy  out  1  a command or the power-on reset sequence is in progress.
- tck_en  out  1  TAP step strobe; the TAP samples TMS/TDI on this cycle.
- TMS  out  1  test mode select for the current step.
- TDI  out  1  test data in for the current step.
- TDO  in  1  test data out from the TAP, sampled on shift steps.

## Operation
- States: RST_SEQ, IDLE, PRE, SHIFT, POST, DONE.
- Length normalisation: cmd_len=0 is treated as 1; cmd_len>MAX_LEN is treated as MAX_LEN. L denotes the normalised length.
- RST_SEQ: 5 steps with TMS=1, then 1 step with TMS=0, leaving the TAP in Run-Test/Idle. Entered automatically after nRST release and on cmd_op=00.
- IDLE: cmd_ready=1, tck_en=0, TMS=0. A handshake (cmd_valid & cmd_ready) latches op, L and data, and moves to PRE, RST_SEQ, or SHIFT (idle op).
- PRE, DR scan: TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR).
- PRE, IR scan: TMS 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- SHIFT, scan ops: L steps with TDI=data[i] for i=0..L-1.
  - TMS=0 on steps 0..L-2 and TMS=1 on step L-1, which exits to Exit1.
  - TDO is sampled on every shift step into rsp_data[i].
  - Bits [MAX_LEN-1:L] of rsp_data are 0.
- SHIFT, idle op: L steps with TMS=0 and TDI=0; TDO is ignored.
- POST: TMS 1,0 (Update, Run-Test/Idle).
- DONE: rsp_valid=1 for one cycle. It also drives cmd_ready=1, so a new command can be accepted in this same cycle.
- rsp_data is 0 for the reset and idle ops.
- TDI=0 on every non-shift step.

## Timing
- Reset values (nRST low): TMS=1, TDI=0, tck_en=0, cmd_ready=0, busy=1, rsp_valid=0, rsp_data=0.
- Power-on sequence: on the first cycle after nRST release, tck_en=1 for 6 cycles (TMS 1,1,1,1,1,0). cmd_ready rises on cycle 7 and busy falls on cycle 7.
- Command accepted at edge N: the first step has tck_en=1 in cycle N+1, and steps are contiguous.
- Step counts:
  - DR scan: L+5 steps.
  - IR scan: L+6 steps.
  - Idle op: L steps.
  - TAP reset: 6 steps.
- rsp_valid is asserted in the cycle after the last step. Example: DR scan with L=8 accepted at N gives steps N+1..N+13 and rsp_valid at N+14.
- cmd_ready=0 and busy=1 from the accept edge until the DONE cycle. cmd_valid is ignored while cmd_ready=0.
- Back-to-back commands: a command accepted in the DONE cycle starts its steps in the next cycle, with no gap.
- rsp_data updates only on completion and is stable otherwise.
- nRST asserted mid-command: all outputs go immediately to their reset values. The command is dropped with no rsp_valid, and the power-on sequence reruns after release.

## Test plan
- Power-on: release nRST, then expect tck_en high for 6 cycles with TMS=1,1,1,1,1,0, cmd_ready=1 and busy=0 on cycle 7, and rsp_valid never asserted.
- DR scan: op=10, len=8, data=0xA5, with TDO driven from a 0x3C shift register model. Expect TMS 1,0,0,0×7,1,1,0, TDI bits 1,0,1,0,0,1,0,1 on the shift steps, rsp_data=0x0000003C, and rsp_valid at N+14.
- IR scan: op=01, len=5, data=0x1F, TDO tied to 1. Expect TMS 1,1,0,0,0,0,0,0,1,1,0, 11 steps, and rsp_data=0x0000001F.
- Length boundaries:
  - len=0 behaves as len=1: DR scan of 6 steps, TMS 1,0,0,1,1,0.
  - len=40 clamps to 32: 37 steps, and the full 32-bit TDO word is captured.
- Back-to-back: hold cmd_valid across an idle op with len=3 followed by a DR scan. Expect rsp_valid for the first command in the same cycle the second is accepted, with no tck_en gap.
- Reset mid-scan: assert nRST during the shift step of a len=16 DR scan. Expect outputs at reset values immediately, no rsp_valid, the 6-step reset sequence after release, and rsp_data=0.
